// File: rtl/vp_pkg.sv
// vp_pkg: shared state encoding and default sizing for the vector player.
package vp_pkg;
  localparam int DEF_IN_W = 8;
  localparam int DEF_OUT_W = 8;
  localparam int DEF_DEPTH = 32;
  localparam int ADDR_W = $clog2(DEF_DEPTH);
  localparam int CNT_W = ADDR_W + 1;
  typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} state_e;
  function automatic logic [DEF_IN_W-1:0] vec_stim(input logic [DEF_IN_W+DEF_OUT_W-1:0] v);
    return v[DEF_IN_W+DEF_OUT_W-1 -: DEF_IN_W];
  endfunction
  function automatic logic [DEF_OUT_W-1:0] vec_exp(input logic [DEF_IN_W+DEF_OUT_W-1:0] v);
    return v[DEF_OUT_W-1:0];
  endfunction
endpackage

// File: rtl/vp_vec_mem.sv
// vp_vec_mem: vector store with synchronous write and asynchronous read.
module vp_vec_mem #(
  parameter int W = 16,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/vector_player.sv
// vector_player: replays stored stimulus to a unit under test, samples its
// response after a fixed latency and keeps saturating mismatch bookkeeping.
module vector_player
  import vp_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LAT = 1,
  parameter int ERR_W = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_we,
  input  logic [AW-1:0]         ld_addr,
  input  logic [IN_W+OUT_W-1:0] ld_data,
  input  logic [CW-1:0]         num_vec,
  input  logic                  start,
  output logic [IN_W-1:0]       dut_in,
  input  logic [OUT_W-1:0]      dut_out,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         vec_idx,
  output logic [ERR_W-1:0]      errors,
  output logic                  fail_seen,
  output logic [CW-1:0]         first_fail
);
  localparam int LW = LAT > 1 ? $clog2(LAT) : 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, vec_q, vec_d, ff_q, ff_d, n_clamp;
  logic [LW-1:0] lat_q, lat_d;
  logic [IN_W-1:0] din_q, din_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic fail_q, fail_d, idle;
  logic [IN_W+OUT_W-1:0] rd;
  assign idle = state_q == IDLE || state_q == DONE;
  assign n_clamp = num_vec > CW'(DEPTH) ? CW'(DEPTH) : num_vec;
  // memory is write-protected while a run is in progress
  vp_vec_mem #(.W(IN_W + OUT_W), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we_i(ld_we && idle),
    .waddr_i(ld_addr),
    .wdata_i(ld_data),
    .raddr_i(vec_q[AW-1:0]),
    .rdata_o(rd)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    vec_d = vec_q;
    lat_d = lat_q;
    din_d = din_q;
    err_d = err_q;
    fail_d = fail_q;
    ff_d = ff_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        cnt_d = n_clamp;
        vec_d = '0;
        err_d = '0;
        fail_d = 1'b0;
        ff_d = '0;
        state_d = n_clamp == '0 ? DONE : APPLY;
      end
      APPLY: begin
        din_d = rd[IN_W+OUT_W-1 -: IN_W];
        lat_d = LW'(LAT - 1);
        state_d = LAT == 1 ? CHECK : WAIT;
      end
      WAIT: begin
        lat_d = lat_q - LW'(1);
        state_d = lat_q == LW'(1) ? CHECK : WAIT;
      end
      CHECK: begin
        if (dut_out != rd[OUT_W-1:0]) begin
          err_d = &err_q ? err_q : err_q + ERR_W'(1);
          fail_d = 1'b1;
          ff_d = fail_q ? ff_q : vec_q;
        end
        vec_d = vec_q + CW'(1) == cnt_q ? vec_q : vec_q + CW'(1);
        state_d = vec_q + CW'(1) == cnt_q ? DONE : APPLY;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      vec_q <= '0;
      lat_q <= '0;
      din_q <= '0;
      err_q <= '0;
      fail_q <= 1'b0;
      ff_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      vec_q <= vec_d;
      lat_q <= lat_d;
      din_q <= din_d;
      err_q <= err_d;
      fail_q <= fail_d;
      ff_q <= ff_d;
    end
  assign dut_in = din_q;
  assign busy = state_q == APPLY || state_q == WAIT || state_q == CHECK;
  assign done = state_q == DONE;
  assign vec_idx = vec_q;
  assign errors = err_q;
  assign fail_seen = fail_q;
  assign first_fail = ff_q;
endmodule
